// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for seq_alu.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
    endfunction

    // Among the multi-cycle ops, bit 2 separates divide from multiply.
    function automatic logic is_div_op(input logic [3:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// The accumulator holds {hi, lo}: for multiply {partial product, multiplier},
// for divide {remainder, dividend/quotient}. res/done present the value of the
// final iteration combinationally so the caller can register it on that edge.
module muldiv_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             want_hi_or_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               div_q, div_d;
    logic               hi_q, hi_d;
    logic [WIDTH:0]     mul_sum, trial, trial_diff;

    // One iteration of the active algorithm applied to the current accumulator.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opb_q} : '0);
        trial      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial_diff = trial - {1'b0, opb_q};
        if (div_q) begin
            // Divisor 0 always "fits": quotient fills with ones, remainder ends as a.
            if (trial >= {1'b0, opb_q}) begin
                acc_step = {trial_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign done = busy_q && (cnt_q == LAST);
    assign res  = hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

    // Operand capture on start, then WIDTH iterations while busy.
    always_comb begin
        acc_d  = acc_q;
        opb_d  = opb_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        hi_d   = hi_q;
        if (start) begin
            acc_d  = {{WIDTH{1'b0}}, a};
            opb_d  = b;
            cnt_d  = '0;
            busy_d = 1'b1;
            div_d  = is_div;
            hi_d   = want_hi_or_rem;
        end else if (busy_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Datapath registers; reset aborts any iteration in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            hi_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            hi_q   <= hi_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle fast ops plus iterative mul/div.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | in_ready=1, waiting for in_valid
//   MUL     | shift-add multiply iterating in muldiv_iter
//   DIV     | restoring divide iterating in muldiv_iter
//   DONE    | out_valid=1, result/flags held until out_ready
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             c
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;

    logic             md_start, md_done;
    logic [WIDTH-1:0] md_res;

    logic [WIDTH-1:0] b_eff, sum, fast_res;
    logic [WIDTH:0]   sum_full;
    logic             cout, ovf, fast_v, fast_c;

    assign md_start = in_valid && (state_q == ST_IDLE) && is_multicycle(op);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk            (clk),
        .rst            (rst),
        .start          (md_start),
        .is_div         (is_div_op(op)),
        .want_hi_or_rem (op[0]),
        .a              (a),
        .b              (b),
        .done           (md_done),
        .res            (md_res)
    );

    // Fast-op datapath; SLT reuses the subtractor since op[0]=1 for SLT.
    always_comb begin
        b_eff    = op[0] ? ~b : b;
        sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[0]};
        sum      = sum_full[WIDTH-1:0];
        cout     = sum_full[WIDTH];
        ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        fast_res = '0;
        fast_v   = 1'b0;
        fast_c   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                fast_res = sum;
                fast_v   = ovf;
                fast_c   = cout;
            end
            OP_AND:  fast_res = a & b;
            OP_OR:   fast_res = a | b;
            OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: fast_res = '0;
        endcase
    end

    // Control FSM and result/flag capture.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        c_d      = c_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_multicycle(op)) begin
                        state_d = is_div_op(op) ? ST_DIV : ST_MUL;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = fast_res;
                        z_d      = (fast_res == '0);
                        n_d      = fast_res[WIDTH-1];
                        v_d      = fast_v;
                        c_d      = fast_c;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    result_d = md_res;
                    z_d      = (md_res == '0);
                    n_d      = md_res[WIDTH-1];
                    v_d      = 1'b0;
                    c_d      = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            c_q      <= c_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign z         = z_q;
    assign n         = n_q;
    assign v         = v_q;
    assign c         = c_q;

endmodule
